// File: rtl/tremolo_ctrl.sv
// tremolo_ctrl: triangle-LFO gain scheduler for the tremolo stage, with click-free fade in/out.
// Optional square LFO select (wave_sel port) is built when TREMOLO_CTRL_SQUARE_EN is defined.
module tremolo_ctrl #(
  parameter int GAIN_W      = 11,
  parameter int DIV_SAMPLES = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_stb,
  input  logic              tremolo_sw,
  input  logic [3:0]        rate,
  input  logic [3:0]        depth,
`ifdef TREMOLO_CTRL_SQUARE_EN
  input  logic              wave_sel,
`endif
  output logic [GAIN_W-1:0] gain,
  output logic              gain_valid,
  output logic              bypass
);

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    RUN,
    FADE_OUT
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(DIV_SAMPLES - 1);
  localparam logic [9:0]  AMP_MAX   = 10'd1023;
  localparam logic [4:0]  MIX_FULL  = 5'd16;

  state_t            state_q, state_d;
  logic [15:0]       tick_cnt_q, tick_cnt_d;
  logic [9:0]        amp_q, amp_d;
  logic              dir_down_q, dir_down_d;
  logic [4:0]        mix_q, mix_d;
  logic [3:0]        rate_sh_q, rate_sh_d;
  logic [3:0]        depth_sh_q, depth_sh_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              gain_valid_q, gain_valid_d;
  logic              bypass_q, bypass_d;

  logic              tick;
  logic              at_trough;
  logic [4:0]        step;
  logic [10:0]       amp_up;
  logic [9:0]        amp_eff;
  logic [13:0]       prod;
  logic [9:0]        mod;
  logic [10:0]       att;
  logic [10:0]       gain_calc;

`ifdef TREMOLO_CTRL_SQUARE_EN
  logic              wave_sh_q, wave_sh_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      amp_q        <= '0;
      dir_down_q   <= 1'b0;
      mix_q        <= '0;
      rate_sh_q    <= '0;
      depth_sh_q   <= '0;
      gain_q       <= GAIN_W'(11'd1024);
      gain_valid_q <= 1'b0;
      bypass_q     <= 1'b1;
`ifdef TREMOLO_CTRL_SQUARE_EN
      wave_sh_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      amp_q        <= amp_d;
      dir_down_q   <= dir_down_d;
      mix_q        <= mix_d;
      rate_sh_q    <= rate_sh_d;
      depth_sh_q   <= depth_sh_d;
      gain_q       <= gain_d;
      gain_valid_q <= gain_valid_d;
      bypass_q     <= bypass_d;
`ifdef TREMOLO_CTRL_SQUARE_EN
      wave_sh_q    <= wave_sh_d;
`endif
    end
  end

  always_comb begin
    tick       = sample_stb && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q;
    if (sample_stb) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
    end

    // Settings only change at the trough so a cycle never changes shape halfway through.
    at_trough  = (amp_q == '0) && !dir_down_q;
    rate_sh_d  = rate_sh_q;
    depth_sh_d = depth_sh_q;
`ifdef TREMOLO_CTRL_SQUARE_EN
    wave_sh_d  = wave_sh_q;
`endif
    if ((state_q == IDLE) || at_trough) begin
      rate_sh_d  = rate;
      depth_sh_d = depth;
`ifdef TREMOLO_CTRL_SQUARE_EN
      wave_sh_d  = wave_sel;
`endif
    end

    step       = {1'b0, rate_sh_d} + 5'd1;
    amp_up     = {1'b0, amp_q} + {6'd0, step};
    amp_d      = amp_q;
    dir_down_d = dir_down_q;
    if (tick && (state_q != IDLE)) begin
      if (!dir_down_q) begin
        if (amp_up >= {1'b0, AMP_MAX}) begin
          amp_d      = AMP_MAX;
          dir_down_d = 1'b1;
        end else begin
          amp_d = amp_up[9:0];
        end
      end else if (amp_q <= {5'd0, step}) begin
        amp_d      = '0;
        dir_down_d = 1'b0;
      end else begin
        amp_d = amp_q - {5'd0, step};
      end
    end

    state_d = state_q;
    mix_d   = mix_q;
    case (state_q)
      IDLE: begin
        mix_d = '0;
        if (tremolo_sw) state_d = FADE_IN;
      end
      FADE_IN: begin
        if (!tremolo_sw) begin
          state_d = FADE_OUT;
        end else begin
          if (tick && (mix_q < MIX_FULL)) mix_d = mix_q + 5'd1;
          if (mix_d == MIX_FULL) state_d = RUN;
        end
      end
      RUN: begin
        mix_d = MIX_FULL;
        if (!tremolo_sw) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (tremolo_sw) begin
          state_d = FADE_IN;
        end else begin
          if (tick && (mix_q != '0)) mix_d = mix_q - 5'd1;
          if (mix_d == '0) begin
            state_d    = IDLE;
            amp_d      = '0;
            dir_down_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    amp_eff = amp_d;
`ifdef TREMOLO_CTRL_SQUARE_EN
    if (wave_sh_d) amp_eff = dir_down_d ? AMP_MAX : '0;
`endif

    // Both scalings truncate; worst case att = 959 keeps gain >= 65.
    prod      = 14'(amp_eff) * 14'(depth_sh_d);
    mod       = 10'(prod >> 4);
    att       = 11'((15'(mod) * 15'(mix_d)) >> 4);
    gain_calc = 11'd1024 - att;

    gain_d       = sample_stb ? GAIN_W'(gain_calc) : gain_q;
    gain_valid_d = sample_stb;
    bypass_d     = (state_d == IDLE);
  end

  assign gain       = gain_q;
  assign gain_valid = gain_valid_q;
  assign bypass     = bypass_q;

endmodule
